// File: rtl/result_reporter.sv
// result_reporter: prints a captured 32-bit program return value to a byte
// sink as 8 ASCII hex characters, most significant nibble first.
//
// Optional feature: define RESULT_EOL_EN to append CR (0x0D) and LF (0x0A)
// after the hex digits (10 bytes per report instead of 8).
//
// Parameters:
//   HEX_UPPER     1: digits 10-15 as 'A'-'F', 0: as 'a'-'f'
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   halt          one-cycle program-finished pulse; ignored while busy
//   return_value  value to report, sampled only when a halt is accepted
//   tx_data       ASCII byte to the sink (0x00 when not sending)
//   tx_valid      tx_data valid; a byte moves on tx_valid && tx_ready
//   tx_ready      sink accepts the byte
//   busy          report in progress
//   done          last byte of the most recent report was accepted
//   report_count  completed reports, modulo 256
module result_reporter #(
  parameter int HEX_UPPER = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic [31:0] return_value,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  report_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_HEX = 2'd1;
`ifdef RESULT_EOL_EN
  localparam logic [1:0] SEND_EOL = 2'd2;
`endif
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]  state;
  logic [31:0] shadow;
  logic [2:0]  idx;
  logic [3:0]  nib;
`ifdef RESULT_EOL_EN
  logic        eol_sel;  // 0: CR pending, 1: LF pending
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (HEX_UPPER != 0 ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign nib = shadow[{idx, 2'b00} +: 4];

  // Outputs are decoded from state, so tx_valid rises right after the halt
  // edge and data stays put while the sink stalls (shadow/idx only move on
  // a transfer).
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      SEND_HEX: begin
        tx_valid = 1'b1;
        tx_data  = hex_char(nib);
      end
`ifdef RESULT_EOL_EN
      SEND_EOL: begin
        tx_valid = 1'b1;
        tx_data  = eol_sel ? 8'h0A : 8'h0D;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      idx          <= 3'd7;
      busy         <= 1'b0;
      done         <= 1'b0;
      report_count <= 8'd0;
`ifdef RESULT_EOL_EN
      eol_sel      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (halt) begin
            shadow <= return_value;
            idx    <= 3'd7;
            busy   <= 1'b1;
            done   <= 1'b0;
            state  <= SEND_HEX;
          end
        end
        SEND_HEX: begin
          if (tx_ready) begin
            idx <= idx - 3'd1;
            if (idx == 3'd0) begin
`ifdef RESULT_EOL_EN
              state   <= SEND_EOL;
              eol_sel <= 1'b0;
`else
              // Final byte: halt on this edge is not seen since busy is set.
              state        <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              report_count <= report_count + 8'd1;
`endif
            end
          end
        end
`ifdef RESULT_EOL_EN
        SEND_EOL: begin
          if (tx_ready) begin
            eol_sel <= 1'b1;
            if (eol_sel) begin
              state        <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              report_count <= report_count + 8'd1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_reporter.sv
// Randomized + directed bench for result_reporter. Two instances (upper and
// lower case hex) share the inputs; a queue-of-characters reference model
// predicts every output after every clock edge.
module tb_result_reporter;

`ifdef RESULT_EOL_EN
  localparam int NB = 10;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, halt, tx_ready;
  logic [31:0] return_value;
  logic [7:0]  data_up, data_lo, cnt_up, cnt_lo;
  logic        vld_up, vld_lo, busy_up, busy_lo, done_up, done_lo;

  result_reporter #(.HEX_UPPER(1)) u_up (
    .clk(clk), .rst_n(rst_n), .halt(halt), .return_value(return_value),
    .tx_data(data_up), .tx_valid(vld_up), .tx_ready(tx_ready),
    .busy(busy_up), .done(done_up), .report_count(cnt_up));

  result_reporter #(.HEX_UPPER(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .halt(halt), .return_value(return_value),
    .tx_data(data_lo), .tx_valid(vld_lo), .tx_ready(tx_ready),
    .busy(busy_lo), .done(done_lo), .report_count(cnt_lo));

  int vectors = 0;
  int miscompares = 0;

  // Model: pending characters of the current report (0-15 nibble, 16 CR, 17 LF).
  int         q[$];
  bit         m_done = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] ascii(input int code, input bit up);
    if (code < 10)       return 8'(48 + code);
    else if (code < 16)  return 8'((up ? 65 : 97) + code - 10);
    else if (code == 16) return 8'h0D;
    else                 return 8'h0A;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
      m_cnt  = 8'd0;
    end else if (q.size() == 0) begin
      if (halt) begin
        for (int i = 7; i >= 0; i--) q.push_back(int'((return_value >> (4 * i)) & 32'hF));
`ifdef RESULT_EOL_EN
        q.push_back(16);
        q.push_back(17);
`endif
        m_done = 1'b0;
      end
    end else if (tx_ready) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_done = 1'b1;
        m_cnt  = m_cnt + 8'd1;
      end
    end
  endtask

  task automatic check_outs();
    logic       ev;
    logic [7:0] eu, el;
    ev = (q.size() != 0);
    eu = ev ? ascii(q[0], 1'b1) : 8'h00;
    el = ev ? ascii(q[0], 1'b0) : 8'h00;
    chk("vld_up",  vld_up,  ev);
    chk("vld_lo",  vld_lo,  ev);
    chk("data_up", data_up, eu);
    chk("data_lo", data_lo, el);
    chk("busy_up", busy_up, ev);
    chk("busy_lo", busy_lo, ev);
    chk("done_up", done_up, m_done);
    chk("done_lo", done_lo, m_done);
    chk("cnt_up",  cnt_up,  m_cnt);
    chk("cnt_lo",  cnt_lo,  m_cnt);
  endtask

  task automatic step(input logic h, input logic [31:0] rv, input logic rdy, input logic rn);
    rst_n = rn; halt = h; return_value = rv; tx_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; tx_ready = 1'b1; return_value = '0;

    // Reset (halt asserted during reset must be ignored)
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h5555AAAA, 1'b1, 1'b0);

    // 0x2A with a always-ready sink
    step(1'b1, 32'h0000002A, 1'b1, 1'b1);
    chk("first_char", data_up, 8'h30);
    repeat (NB) step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1);
    chk("done_2a", done_up, 1'b1);
    chk("cnt_2a", cnt_up, 8'd1);

    // 0xDEADBEEF with ready toggling; return_value scrambled afterwards
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("first_lo", data_lo, 8'h64);
    for (int i = 0; i < 2 * NB + 2; i++) step(1'b0, $urandom, 1'(i % 2 == 0), 1'b1);
    chk("cnt_beef", cnt_up, 8'd2);

    // Second halt during byte 3 is ignored
    step(1'b1, 32'hCAFE0001, 1'b1, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h12345678, 1'b1, 1'b1);
    repeat (NB) step(1'b0, 32'h12345678, 1'b1, 1'b1);
    chk("cnt_dbl", cnt_up, 8'd3);

    // Reset after byte 4 abandons the report
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h89ABCDEF, 1'b1, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("cnt_rst", cnt_up, 8'd0);
    chk("vld_rst", vld_up, 1'b0);
    step(1'b1, 32'h0F1E2D3C, 1'b1, 1'b1);
    repeat (NB) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("cnt_after_rst", cnt_up, 8'd1);

    // Halt on the final transfer edge is ignored; one cycle later it starts
    step(1'b1, 32'h00000001, 1'b1, 1'b1);
    repeat (NB - 1) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h77777777, 1'b1, 1'b1);
    chk("vld_final_halt", vld_up, 1'b0);
    step(1'b1, 32'hA0A0A0A0, 1'b1, 1'b1);
    chk("restart", data_up, 8'h41);
    repeat (NB) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("cnt_final_halt", cnt_up, 8'd3);

    // 256 back-to-back reports wrap the counter
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int r = 0; r < 256; r++) begin
      step(1'b1, $urandom, 1'b1, 1'b1);
      repeat (NB) step(1'b0, $urandom, 1'b1, 1'b1);
    end
    chk("cnt_wrap", cnt_up, 8'd0);
    chk("done_wrap", done_up, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 5) == 0), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_reporter.md
RESULT_REPORTER -- requirements
Module: result_reporter

Interface
REQ-001 Parameter: HEX_UPPER, default 1, 1 selects 'A'-'F' (0x41-0x46) and 0 selects 'a'-'f' (0x61-0x66) for hex digits 10-15.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 halt  input  1  one-cycle pulse from the core when the program finishes (ecall/ebreak).
REQ-005 return_value  input  32  captured a0 value, sampled only on an accepted halt.
REQ-006 tx_data  output  8  ASCII byte to the host byte sink.
REQ-007 tx_valid  output  1  tx_data is valid.
REQ-008 tx_ready  input  1  sink accepts the byte; a transfer occurs when tx_valid && tx_ready on a rising edge.
REQ-009 busy  output  1  report in progress.
REQ-010 done  output  1  last byte of the most recent report was accepted.
REQ-011 report_count  output  8  number of completed reports.

Function
REQ-012 FSM states shall be IDLE, SEND_HEX, SEND_EOL (only when RESULT_EOL_EN is defined) and DONE.
REQ-013 IDLE or DONE with halt=1 shall latch return_value into a shadow register, clear done, set busy, set the nibble index to 7 and enter SEND_HEX on that edge.
REQ-014 Latency: halt at edge N shall give tx_valid=1 with the first character after edge N.
REQ-015 SEND_HEX shall present the ASCII hex of shadow[4*idx+3:4*idx], MSB nibble first: digits 0-9 map to 0x30-0x39, and 10-15 map per HEX_UPPER.
REQ-016 tx_valid shall stay high, and tx_data plus the shadow register shall stay stable, while tx_valid && !tx_ready; no byte shall be dropped or repeated.
REQ-017 On each transfer in SEND_HEX, idx shall decrement; the transfer at idx=0 shall move to SEND_EOL if RESULT_EOL_EN is defined, otherwise to DONE.
REQ-018 The sink may hold tx_ready high continuously; the block shall then sustain one byte per cycle with no idle bubbles inside a report.
REQ-019 On the final transfer, the block shall set done=1, clear busy, drop tx_valid on the next cycle, and increment report_count modulo 256 (255 wraps to 0).
REQ-020 halt while busy=1 shall be ignored, and the shadow register and report_count shall be unaffected.
REQ-021 halt coincident with the final transfer shall be ignored, because busy is still 1 on that edge.
REQ-022 In DONE, done shall stay 1 and tx_valid 0 until the next halt restarts the sequence per REQ-013.
REQ-023 return_value changes after an accepted halt shall not affect the report in progress.
REQ-024 tx_valid shall be 0 in IDLE and DONE.

Reset
REQ-025 With rst_n=0 at a rising edge, the block shall enter IDLE with tx_valid=0, tx_data=0x00, busy=0, done=0, report_count=0, idx=7 and shadow=0, regardless of its current state.
REQ-026 Reset mid-report shall abandon the report with no further bytes, and the abandoned report shall not be counted.
REQ-027 halt while rst_n=0 shall be ignored.

Configuration
REQ-028 Macro RESULT_EOL_EN, when defined, shall make SEND_EOL append 0x0D then 0x0A after the 8 hex bytes, using the same handshake, for 10 bytes per report.
REQ-029 Without RESULT_EOL_EN, a report shall be exactly 8 bytes and the SEND_EOL state shall not exist.

Verification
REQ-030 return_value=0x0000002A, halt pulse, tx_ready=1 -> bytes 30 30 30 30 30 30 32 41 on 8 consecutive cycles (+0D 0A with RESULT_EOL_EN), then done=1 and report_count=1.
REQ-031 return_value=0xDEADBEEF, HEX_UPPER=0, tx_ready toggling 1/0 each cycle -> bytes 64 65 61 64 62 65 65 66, each held stable while tx_ready=0.
REQ-032 Second halt during byte 3, with return_value changed to 0x12345678 -> the report still shows the first value and report_count increments by 1 only.
REQ-033 rst_n=0 for one edge after byte 4 -> tx_valid=0, busy=0, done=0 and report_count unchanged at 0; a following halt yields a full 8-byte report.
REQ-034 256 back-to-back reports -> report_count wraps to 0x00 after the 256th, with done=1.
REQ-035 halt on the same edge as the final transfer -> ignored, then DONE; a halt one cycle later starts a new report with first tx_valid after that edge.
